// File: rtl/keypad_lock_ctrl_pkg.sv
// Shared state encodings for the keypad lock controller and its benches.
package lock_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_LOCKED   = 3'b000,
        S_INPUT    = 3'b001,
        S_VERIFY   = 3'b010,
        S_ERROR    = 3'b011,
        S_UNLOCKED = 3'b100,
        S_LOCKOUT  = 3'b101,
        S_PROGRAM  = 3'b110
    } state_t;

endpackage

// File: rtl/keypad_lock_ctrl_if.sv
// Keypad-side inputs and status outputs of the lock controller.
interface keypad_lock_ctrl_if #(
    parameter int DIGIT_W = 4,
    parameter int DCNT_W  = 3,
    parameter int FCNT_W  = 2
);
    logic               key_valid;
    logic [DIGIT_W-1:0] key_digit;
    logic               key_clear;
    logic               relock;
    logic               prog_en;
    logic [2:0]         state;
    logic               unlocked;
    logic               error;
    logic               lockout;
    logic [DCNT_W-1:0]  digit_cnt;
    logic [FCNT_W-1:0]  fail_cnt;

    modport master (
        output key_valid, key_digit, key_clear, relock, prog_en,
        input  state, unlocked, error, lockout, digit_cnt, fail_cnt
    );

    modport slave (
        input  key_valid, key_digit, key_clear, relock, prog_en,
        output state, unlocked, error, lockout, digit_cnt, fail_cnt
    );
endinterface

// File: rtl/keypad_lock_ctrl_timer.sv
// Loadable down-counter shared by the lockout and unlock timeouts.
// expired flags the last cycle of a loaded period (count at 1), so a
// load of N keeps the owning state alive for exactly N cycles.
module lock_timer #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expired
);
    logic [W-1:0] count;

    // Load wins over counting; stop at zero so the counter never wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && count != '0) begin
            count <= count - W'(1);
        end
    end

    assign expired = (count <= W'(1));
endmodule

// File: rtl/keypad_lock_ctrl.sv
// Keypad lock sequencing controller: entry collection, code compare,
// failure counting with lockout, auto-relock and code reprogramming.
//
// state    | meaning
// ---------+---------------------------------------------------------
// LOCKED   | idle, waiting for the first digit
// INPUT    | collecting digits into the entry buffer
// VERIFY   | one cycle: compare entry buffer with stored code
// ERROR    | one cycle: wrong code reported
// UNLOCKED | door open, relock timer running
// LOCKOUT  | too many failures, inputs ignored until timer expires
// PROGRAM  | collecting a new code, timer frozen
module keypad_lock_ctrl
    import lock_pkg::*;
#(
    parameter int CODE_LEN       = 4,
    parameter int DIGIT_W        = 4,
    parameter int MAX_TRIES      = 3,
    parameter int LOCKOUT_CYCLES = 16,
    parameter int UNLOCK_CYCLES  = 32,
    parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = 16'h1234
) (
    input logic               clk,
    input logic               reset,
    keypad_lock_ctrl_if.slave bus
);
    localparam int CW    = CODE_LEN * DIGIT_W;
    localparam int DW    = $clog2(CODE_LEN + 1);
    localparam int FW    = $clog2(MAX_TRIES + 1);
    localparam int TMAX  = (LOCKOUT_CYCLES > UNLOCK_CYCLES) ? LOCKOUT_CYCLES : UNLOCK_CYCLES;
    localparam int TW    = $clog2(TMAX + 1);

    state_t        state, state_nxt;
    logic [CW-1:0] code, code_nxt;
    logic [CW-1:0] entry_buf, buf_nxt, slot_buf;
    logic [DW-1:0] digit_cnt, dcnt_nxt, dcnt_inc;
    logic [FW-1:0] fail_cnt, fcnt_nxt, fcnt_inc;
    logic          tmr_load, tmr_en, tmr_expired;
    logic [TW-1:0] tmr_val;

    lock_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .expired  (tmr_expired)
    );

    assign dcnt_inc = digit_cnt + DW'(1);
    assign fcnt_inc = fail_cnt + FW'(1);

    // Entry buffer with the incoming digit placed at slot digit_cnt (slot 0 = MSD).
    always_comb begin
        slot_buf = entry_buf;
        for (int i = 0; i < CODE_LEN; i++) begin
            if (int'(digit_cnt) == i) begin
                slot_buf[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W] = bus.key_digit;
            end
        end
    end

    // Register all controller state; reset restores the factory code.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_LOCKED;
            code      <= DEFAULT_CODE;
            entry_buf <= '0;
            digit_cnt <= '0;
            fail_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            code      <= code_nxt;
            entry_buf <= buf_nxt;
            digit_cnt <= dcnt_nxt;
            fail_cnt  <= fcnt_nxt;
        end
    end

    // Next-state, counter updates and timer control.
    always_comb begin
        state_nxt = state;
        code_nxt  = code;
        buf_nxt   = entry_buf;
        dcnt_nxt  = digit_cnt;
        fcnt_nxt  = fail_cnt;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        tmr_en    = 1'b0;

        case (state)
            S_LOCKED: begin
                if (bus.key_valid) begin
                    buf_nxt   = slot_buf;
                    dcnt_nxt  = DW'(1);
                    state_nxt = (CODE_LEN == 1) ? S_VERIFY : S_INPUT;
                end
            end
            S_INPUT: begin
                if (bus.key_clear) begin
                    dcnt_nxt  = '0;
                    state_nxt = S_LOCKED;
                end else if (bus.key_valid) begin
                    buf_nxt  = slot_buf;
                    dcnt_nxt = dcnt_inc;
                    if (dcnt_inc == DW'(CODE_LEN)) begin
                        state_nxt = S_VERIFY;
                    end
                end
            end
            S_VERIFY: begin
                dcnt_nxt = '0;
                if (entry_buf == code) begin
                    fcnt_nxt  = '0;
                    tmr_load  = 1'b1;
                    tmr_val   = TW'(UNLOCK_CYCLES);
                    state_nxt = S_UNLOCKED;
                end else begin
                    fcnt_nxt = fcnt_inc;
                    if (fcnt_inc == FW'(MAX_TRIES)) begin
                        tmr_load  = 1'b1;
                        tmr_val   = TW'(LOCKOUT_CYCLES);
                        state_nxt = S_LOCKOUT;
                    end else begin
                        state_nxt = S_ERROR;
                    end
                end
            end
            S_ERROR: begin
                state_nxt = S_LOCKED;
            end
            S_LOCKOUT: begin
                tmr_en = 1'b1;
                if (tmr_expired) begin
                    fcnt_nxt  = '0;
                    state_nxt = S_LOCKED;
                end
            end
            S_UNLOCKED: begin
                tmr_en = 1'b1;
                if (bus.relock || tmr_expired) begin
                    state_nxt = S_LOCKED;
                end else if (bus.prog_en) begin
                    dcnt_nxt  = '0;
                    state_nxt = S_PROGRAM;
                end
            end
            S_PROGRAM: begin
                if (bus.key_clear) begin
                    dcnt_nxt  = '0;
                    tmr_load  = 1'b1;
                    tmr_val   = TW'(UNLOCK_CYCLES);
                    state_nxt = S_UNLOCKED;
                end else if (bus.key_valid) begin
                    buf_nxt = slot_buf;
                    if (dcnt_inc == DW'(CODE_LEN)) begin
                        code_nxt  = slot_buf;
                        dcnt_nxt  = '0;
                        tmr_load  = 1'b1;
                        tmr_val   = TW'(UNLOCK_CYCLES);
                        state_nxt = S_UNLOCKED;
                    end else begin
                        dcnt_nxt = dcnt_inc;
                    end
                end
            end
            default: begin
                dcnt_nxt  = '0;
                state_nxt = S_LOCKED;
            end
        endcase
    end

    assign bus.state     = state;
    assign bus.unlocked  = (state == S_UNLOCKED);
    assign bus.error     = (state == S_ERROR);
    assign bus.lockout   = (state == S_LOCKOUT);
    assign bus.digit_cnt = digit_cnt;
    assign bus.fail_cnt  = fail_cnt;
endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// Scenario bench for keypad_lock_ctrl: each scenario builds a per-cycle
// stimulus plan with the expected post-edge status, the expectation is
// queued as the stimulus is driven and popped once the edge has passed.
module tb_keypad_lock_ctrl;
    import lock_pkg::*;

    typedef struct {
        logic       kv;
        logic [3:0] kd;
        logic       kc;
        logic       rl;
        logic       pe;
        logic       rs;
        logic [2:0] st;
        logic [2:0] dc;
        logic [1:0] fc;
    } stim_t;

    logic  clk = 1'b0;
    logic  reset;
    int    n_checks = 0;
    int    n_fail = 0;
    stim_t plan[$];
    stim_t sb_q[$];

    keypad_lock_ctrl_if #(.DIGIT_W(4), .DCNT_W(3), .FCNT_W(2)) bus ();

    keypad_lock_ctrl #(
        .CODE_LEN(4), .DIGIT_W(4), .MAX_TRIES(3),
        .LOCKOUT_CYCLES(16), .UNLOCK_CYCLES(32), .DEFAULT_CODE(16'h1234)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic add(input logic kv, input logic [3:0] kd, input logic kc,
                       input logic rl, input logic pe, input logic rs,
                       input logic [2:0] st, input logic [2:0] dc, input logic [1:0] fc);
        stim_t s;
        s.kv = kv; s.kd = kd; s.kc = kc; s.rl = rl; s.pe = pe; s.rs = rs;
        s.st = st; s.dc = dc; s.fc = fc;
        plan.push_back(s);
    endtask

    task automatic idle(input logic [2:0] st, input logic [2:0] dc, input logic [1:0] fc);
        add(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, st, dc, fc);
    endtask

    // Four digits from LOCKED: INPUT 1..3, then VERIFY with fail count unchanged.
    task automatic add_code(input logic [15:0] c, input logic [1:0] fc);
        add(1'b1, c[15:12], 1'b0, 1'b0, 1'b0, 1'b0, S_INPUT,  3'd1, fc);
        add(1'b1, c[11:8],  1'b0, 1'b0, 1'b0, 1'b0, S_INPUT,  3'd2, fc);
        add(1'b1, c[7:4],   1'b0, 1'b0, 1'b0, 1'b0, S_INPUT,  3'd3, fc);
        add(1'b1, c[3:0],   1'b0, 1'b0, 1'b0, 1'b0, S_VERIFY, 3'd4, fc);
    endtask

    task automatic run_one(input stim_t s);
        bus.key_valid = s.kv;
        bus.key_digit = s.kd;
        bus.key_clear = s.kc;
        bus.relock    = s.rl;
        bus.prog_en   = s.pe;
        reset         = s.rs;
        sb_q.push_back(s);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        stim_t e;
        plan.delete();
        add(1'b1, 4'h7, 1'b1, 1'b1, 1'b1, 1'b1, S_LOCKED, 3'd0, 2'd0);
        idle(S_LOCKED, 3'd0, 2'd0);
        idle(S_LOCKED, 3'd0, 2'd0);
        for (int i = 0; i < plan.size(); i++) begin
            run_one(plan[i]);
            e = sb_q.pop_front();
            n_checks++;
            if (bus.state !== e.st || bus.digit_cnt !== e.dc || bus.fail_cnt !== e.fc ||
                bus.unlocked !== (e.st == S_UNLOCKED) || bus.error !== (e.st == S_ERROR) ||
                bus.lockout !== (e.st == S_LOCKOUT)) begin
                n_fail++;
                $display("FAIL reset[%0d]: got st=%0d dc=%0d fc=%0d u=%b e=%b l=%b, expected st=%0d dc=%0d fc=%0d",
                         i, bus.state, bus.digit_cnt, bus.fail_cnt, bus.unlocked, bus.error,
                         bus.lockout, e.st, e.dc, e.fc);
            end
        end
    endtask

    task automatic test_unlock_timeout();
        stim_t e;
        plan.delete();
        add_code(16'h1234, 2'd0);
        for (int k = 0; k < 32; k++) idle(S_UNLOCKED, 3'd0, 2'd0);
        idle(S_LOCKED, 3'd0, 2'd0);
        for (int i = 0; i < plan.size(); i++) begin
            run_one(plan[i]);
            e = sb_q.pop_front();
            n_checks++;
            if (bus.state !== e.st || bus.digit_cnt !== e.dc || bus.fail_cnt !== e.fc ||
                bus.unlocked !== (e.st == S_UNLOCKED) || bus.error !== (e.st == S_ERROR) ||
                bus.lockout !== (e.st == S_LOCKOUT)) begin
                n_fail++;
                $display("FAIL unlock_timeout[%0d]: got st=%0d dc=%0d fc=%0d u=%b e=%b l=%b, expected st=%0d dc=%0d fc=%0d",
                         i, bus.state, bus.digit_cnt, bus.fail_cnt, bus.unlocked, bus.error,
                         bus.lockout, e.st, e.dc, e.fc);
            end
        end
    endtask

    task automatic test_lockout();
        stim_t e;
        plan.delete();
        add_code(16'h1235, 2'd0);
        idle(S_ERROR, 3'd0, 2'd1);
        idle(S_LOCKED, 3'd0, 2'd1);
        add_code(16'h1235, 2'd1);
        idle(S_ERROR, 3'd0, 2'd2);
        idle(S_LOCKED, 3'd0, 2'd2);
        add_code(16'h1235, 2'd2);
        for (int k = 0; k < 16; k++)
            add(1'b1, 4'($urandom_range(15)), 1'b0, 1'b0, 1'b0, 1'b0, S_LOCKOUT, 3'd0, 2'd3);
        idle(S_LOCKED, 3'd0, 2'd0);
        idle(S_LOCKED, 3'd0, 2'd0);
        for (int i = 0; i < plan.size(); i++) begin
            run_one(plan[i]);
            e = sb_q.pop_front();
            n_checks++;
            if (bus.state !== e.st || bus.digit_cnt !== e.dc || bus.fail_cnt !== e.fc ||
                bus.unlocked !== (e.st == S_UNLOCKED) || bus.error !== (e.st == S_ERROR) ||
                bus.lockout !== (e.st == S_LOCKOUT)) begin
                n_fail++;
                $display("FAIL lockout[%0d]: got st=%0d dc=%0d fc=%0d u=%b e=%b l=%b, expected st=%0d dc=%0d fc=%0d",
                         i, bus.state, bus.digit_cnt, bus.fail_cnt, bus.unlocked, bus.error,
                         bus.lockout, e.st, e.dc, e.fc);
            end
        end
    endtask

    task automatic test_clear();
        stim_t e;
        plan.delete();
        add(1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, S_INPUT, 3'd1, 2'd0);
        add(1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, S_INPUT, 3'd2, 2'd0);
        add(1'b1, 4'h3, 1'b1, 1'b0, 1'b0, 1'b0, S_LOCKED, 3'd0, 2'd0);
        add_code(16'h1234, 2'd0);
        idle(S_UNLOCKED, 3'd0, 2'd0);
        add(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, S_LOCKED, 3'd0, 2'd0);
        for (int i = 0; i < plan.size(); i++) begin
            run_one(plan[i]);
            e = sb_q.pop_front();
            n_checks++;
            if (bus.state !== e.st || bus.digit_cnt !== e.dc || bus.fail_cnt !== e.fc ||
                bus.unlocked !== (e.st == S_UNLOCKED) || bus.error !== (e.st == S_ERROR) ||
                bus.lockout !== (e.st == S_LOCKOUT)) begin
                n_fail++;
                $display("FAIL clear[%0d]: got st=%0d dc=%0d fc=%0d u=%b e=%b l=%b, expected st=%0d dc=%0d fc=%0d",
                         i, bus.state, bus.digit_cnt, bus.fail_cnt, bus.unlocked, bus.error,
                         bus.lockout, e.st, e.dc, e.fc);
            end
        end
    endtask

    task automatic test_program();
        stim_t e;
        plan.delete();
        add_code(16'h1234, 2'd0);
        idle(S_UNLOCKED, 3'd0, 2'd0);
        add(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, S_PROGRAM, 3'd0, 2'd0);
        add(1'b1, 4'h9, 1'b0, 1'b0, 1'b0, 1'b0, S_PROGRAM, 3'd1, 2'd0);
        add(1'b1, 4'h8, 1'b0, 1'b0, 1'b0, 1'b0, S_PROGRAM, 3'd2, 2'd0);
        add(1'b1, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0, S_PROGRAM, 3'd3, 2'd0);
        add(1'b1, 4'h6, 1'b0, 1'b0, 1'b0, 1'b0, S_UNLOCKED, 3'd0, 2'd0);
        add(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, S_LOCKED, 3'd0, 2'd0);
        add_code(16'h1234, 2'd0);
        idle(S_ERROR, 3'd0, 2'd1);
        idle(S_LOCKED, 3'd0, 2'd1);
        add_code(16'h9876, 2'd1);
        idle(S_UNLOCKED, 3'd0, 2'd0);
        add(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, S_LOCKED, 3'd0, 2'd0);
        for (int i = 0; i < plan.size(); i++) begin
            run_one(plan[i]);
            e = sb_q.pop_front();
            n_checks++;
            if (bus.state !== e.st || bus.digit_cnt !== e.dc || bus.fail_cnt !== e.fc ||
                bus.unlocked !== (e.st == S_UNLOCKED) || bus.error !== (e.st == S_ERROR) ||
                bus.lockout !== (e.st == S_LOCKOUT)) begin
                n_fail++;
                $display("FAIL program[%0d]: got st=%0d dc=%0d fc=%0d u=%b e=%b l=%b, expected st=%0d dc=%0d fc=%0d",
                         i, bus.state, bus.digit_cnt, bus.fail_cnt, bus.unlocked, bus.error,
                         bus.lockout, e.st, e.dc, e.fc);
            end
        end
    endtask

    task automatic test_relock_reset();
        stim_t e;
        plan.delete();
        add_code(16'h9876, 2'd0);
        for (int k = 0; k < 4; k++) idle(S_UNLOCKED, 3'd0, 2'd0);
        add(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, S_LOCKED, 3'd0, 2'd0);
        add_code(16'h9876, 2'd0);
        idle(S_UNLOCKED, 3'd0, 2'd0);
        add(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, S_PROGRAM, 3'd0, 2'd0);
        add(1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0, S_PROGRAM, 3'd1, 2'd0);
        add(1'b1, 4'h6, 1'b0, 1'b0, 1'b0, 1'b0, S_PROGRAM, 3'd2, 2'd0);
        add(1'b1, 4'h7, 1'b0, 1'b0, 1'b0, 1'b1, S_LOCKED, 3'd0, 2'd0);
        add_code(16'h1234, 2'd0);
        idle(S_UNLOCKED, 3'd0, 2'd0);
        add(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, S_LOCKED, 3'd0, 2'd0);
        for (int i = 0; i < plan.size(); i++) begin
            run_one(plan[i]);
            e = sb_q.pop_front();
            n_checks++;
            if (bus.state !== e.st || bus.digit_cnt !== e.dc || bus.fail_cnt !== e.fc ||
                bus.unlocked !== (e.st == S_UNLOCKED) || bus.error !== (e.st == S_ERROR) ||
                bus.lockout !== (e.st == S_LOCKOUT)) begin
                n_fail++;
                $display("FAIL relock_reset[%0d]: got st=%0d dc=%0d fc=%0d u=%b e=%b l=%b, expected st=%0d dc=%0d fc=%0d",
                         i, bus.state, bus.digit_cnt, bus.fail_cnt, bus.unlocked, bus.error,
                         bus.lockout, e.st, e.dc, e.fc);
            end
        end
    endtask

    task automatic test_prog_abort();
        stim_t e;
        plan.delete();
        add_code(16'h1234, 2'd0);
        for (int k = 0; k < 4; k++) idle(S_UNLOCKED, 3'd0, 2'd0);
        add(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, S_PROGRAM, 3'd0, 2'd0);
        add(1'b1, 4'h9, 1'b0, 1'b0, 1'b0, 1'b0, S_PROGRAM, 3'd1, 2'd0);
        add(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, S_PROGRAM, 3'd1, 2'd0);
        add(1'b1, 4'h8, 1'b1, 1'b0, 1'b0, 1'b0, S_UNLOCKED, 3'd0, 2'd0);
        for (int k = 0; k < 31; k++) idle(S_UNLOCKED, 3'd0, 2'd0);
        idle(S_LOCKED, 3'd0, 2'd0);
        add_code(16'h1234, 2'd0);
        idle(S_UNLOCKED, 3'd0, 2'd0);
        add(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, S_LOCKED, 3'd0, 2'd0);
        for (int i = 0; i < plan.size(); i++) begin
            run_one(plan[i]);
            e = sb_q.pop_front();
            n_checks++;
            if (bus.state !== e.st || bus.digit_cnt !== e.dc || bus.fail_cnt !== e.fc ||
                bus.unlocked !== (e.st == S_UNLOCKED) || bus.error !== (e.st == S_ERROR) ||
                bus.lockout !== (e.st == S_LOCKOUT)) begin
                n_fail++;
                $display("FAIL prog_abort[%0d]: got st=%0d dc=%0d fc=%0d u=%b e=%b l=%b, expected st=%0d dc=%0d fc=%0d",
                         i, bus.state, bus.digit_cnt, bus.fail_cnt, bus.unlocked, bus.error,
                         bus.lockout, e.st, e.dc, e.fc);
            end
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.key_valid = 1'b0;
        bus.key_digit = 4'h0;
        bus.key_clear = 1'b0;
        bus.relock    = 1'b0;
        bus.prog_en   = 1'b0;
        test_reset();
        test_unlock_timeout();
        test_lockout();
        test_clear();
        test_program();
        test_relock_reset();
        test_prog_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
